// File: rtl/i2s_fifo_pkg.sv
// Shared helpers for the parametrised I2S FIFO.
// Depth sizing and elaboration-time checks live here.
package i2s_fifo_pkg;

  localparam int MAX_DEPTH = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit depth_ok(input int v);
    return (v >= 2) && (v <= MAX_DEPTH) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/i2s_fifo_ptr.sv
// Wrapping AW+1 bit FIFO pointer; MSB is the wrap bit.
// clr wins over inc, rst_n is synchronous active-low.
module i2s_fifo_ptr #(
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [AW:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/i2s_fifo_n.sv
// Parametrised I2S TX/RX FIFO with level, watermark and error flags.
// Sticky ovf/udf flags are built only with I2S_FIFO_ERR_FLAGS_EN.
module i2s_fifo_n
  import i2s_fifo_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic             data_in_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ack,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [AW:0]      fifo_level,
  output logic [AW:0]      fifo_space,
  input  logic [AW:0]      wm_level,
  output logic             wm_hit,
  input  logic             err_clr,
  output logic             ovf_err,
  output logic             udf_err
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("i2s_fifo_n: DEPTH must be a power of two in 2..64");
  end

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] mem [DEPTH];

  i2s_fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fifo_reset),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  i2s_fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fifo_reset),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_space = (AW+1)'(DEPTH) - fifo_level;
  assign wm_hit     = (fifo_level >= wm_level);

  assign data_out_valid = ~fifo_empty;
  assign data_out       = mem[rd_ptr[AW-1:0]];

  // full comes from registered state, so a same-cycle pop cannot free a slot
  assign push        = ~fifo_reset & data_in_valid & ~fifo_full;
  assign pop         = ~fifo_reset & data_out_valid & data_out_ack;
  assign data_in_ack = push;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n)
        mem[i] <= '0;
      else if (push && (wr_ptr[AW-1:0] == AW'(i)))
        mem[i] <= data_in;
    end
  end

`ifdef I2S_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (err_clr || fifo_reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (data_in_valid && fifo_full)
        ovf_q <= 1'b1;
      if (data_out_ack && !data_out_valid)
        udf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf_err        = 1'b0;
  assign udf_err        = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_fifo_n.sv
// Directed bench for i2s_fifo_n at DEPTH=8, WIDTH=16.
// Error-flag expectations follow I2S_FIFO_ERR_FLAGS_EN.
module tb_i2s_fifo_n;

  localparam int W = 16;
  localparam int D = 8;

`ifdef I2S_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_reset;
  logic [W-1:0] data_in;
  logic         data_in_valid;
  logic         data_in_ack;
  logic [W-1:0] data_out;
  logic         data_out_valid;
  logic         data_out_ack;
  logic         fifo_full;
  logic         fifo_empty;
  logic [3:0]   fifo_level;
  logic [3:0]   fifo_space;
  logic [3:0]   wm_level;
  logic         wm_hit;
  logic         err_clr;
  logic         ovf_err;
  logic         udf_err;

  i2s_fifo_n #(.WIDTH(W), .DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_reset     (fifo_reset),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ack    (data_in_ack),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ack   (data_out_ack),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_level     (fifo_level),
    .fifo_space     (fifo_space),
    .wm_level       (wm_level),
    .wm_hit         (wm_hit),
    .err_clr        (err_clr),
    .ovf_err        (ovf_err),
    .udf_err        (udf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         push;
    logic [W-1:0] din;
    logic         pop;
    logic [3:0]   wm;
    logic         e_ack;
    logic [3:0]   e_lvl;
    logic         e_full;
    logic         e_valid;
    logic [W-1:0] e_dout;
    logic         e_wm;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] q[$];
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pu, input logic [W-1:0] di,
                              input logic po, input logic [3:0] wm,
                              input logic ack, input logic [3:0] lvl,
                              input logic [W-1:0] dout, input logic wmh);
    vec_t v;
    v.push    = pu;
    v.din     = di;
    v.pop     = po;
    v.wm      = wm;
    v.e_ack   = ack;
    v.e_lvl   = lvl;
    v.e_full  = (lvl == 4'(D));
    v.e_valid = (lvl != 0);
    v.e_dout  = dout;
    v.e_wm    = wmh;
    return v;
  endfunction

  task automatic drive(input logic pu, input logic [W-1:0] di,
                       input logic po, input logic fr, input logic clr);
    data_in_valid = pu;
    data_in       = di;
    data_out_ack  = po;
    fifo_reset    = fr;
    err_clr       = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    wm_level = 4'd5;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_space", fifo_space, 8);
    chk("rst_dout", data_out, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_udf", udf_err, 0);
    rst_n = 1'b1;

    // fill 1..8, refused 9th, drain 8
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, W'(k), 0, 5, 1, 4'(k), 16'h0001, k >= 5));
    tbl.push_back(mk(1, 16'h0009, 0, 5, 0, 8, 16'h0001, 1));
    for (int j = 1; j <= 8; j++)
      tbl.push_back(mk(0, 0, 1, 5, 0, 4'(8 - j),
                       (j < 8) ? W'(j + 1) : 16'h0001, (8 - j) >= 5));
    // watermark crossing, then boundary thresholds
    for (int m = 1; m <= 5; m++)
      tbl.push_back(mk(1, W'(16'hA0 + m), 0, 5, 1, 4'(m), 16'h00A1, m >= 5));
    tbl.push_back(mk(0, 0, 1, 5, 0, 4, 16'h00A2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 16'h00A2, 1));
    tbl.push_back(mk(0, 0, 0, 9, 0, 4, 16'h00A2, 0));
    tbl.push_back(mk(0, 0, 0, 4, 0, 4, 16'h00A2, 1));
    tbl.push_back(mk(0, 0, 0, 15, 0, 4, 16'h00A2, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].push, tbl[i].din, tbl[i].pop, 1'b0, 1'b0);
      wm_level = tbl[i].wm;
      #1;
      chk($sformatf("v%0d_ack", i), data_in_ack, tbl[i].e_ack);
      if (i == 8)
        chk("ovf_after_full_push", ERR_EN ? 1'b0 : ovf_err, 0);
      tick();
      chk($sformatf("v%0d_level", i), fifo_level, tbl[i].e_lvl);
      chk($sformatf("v%0d_space", i), fifo_space, 4'(D) - tbl[i].e_lvl);
      chk($sformatf("v%0d_full", i), fifo_full, tbl[i].e_full);
      chk($sformatf("v%0d_empty", i), fifo_empty, !tbl[i].e_valid);
      chk($sformatf("v%0d_valid", i), data_out_valid, tbl[i].e_valid);
      chk($sformatf("v%0d_dout", i), data_out, tbl[i].e_dout);
      chk($sformatf("v%0d_wm", i), wm_hit, tbl[i].e_wm);
      if (i == 8)
        chk("ovf_set", ovf_err, ERR_EN);
    end

    wm_level = 4'd5;
    q = '{16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5};
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    void'(q.pop_front());
    chk("lvl3", fifo_level, 3);

    // steady push+pop across pointer wrap
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, W'(16'hB00 + c), 1'b1, 1'b0, 1'b0);
      #1;
      chk($sformatf("cc%0d_ack", c), data_in_ack, 1);
      chk($sformatf("cc%0d_head", c), data_out, q[0]);
      tick();
      q.push_back(W'(16'hB00 + c));
      void'(q.pop_front());
      chk($sformatf("cc%0d_level", c), fifo_level, 3);
    end
    chk("cc_head_end", data_out, q[0]);

    for (int c = 0; c < 5; c++) begin
      drive(1'b1, W'(16'hC1 + c), 1'b0, 1'b0, 1'b0);
      tick();
      q.push_back(W'(16'hC1 + c));
    end
    chk("fill_full", fifo_full, 1);

    drive(1'b1, 16'h00D0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("fullpop_ack", data_in_ack, 0);
    tick();
    void'(q.pop_front());
    chk("fullpop_level", fifo_level, 7);
    chk("fullpop_full", fifo_full, 0);
    chk("fullpop_head", data_out, q[0]);
    chk("fullpop_ovf", ovf_err, ERR_EN);

    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    void'(q.pop_front());
    chk("pre_flush_level", fifo_level, 6);
    chk("pre_flush_head", data_out, q[0]);

    drive(1'b1, 16'h00EE, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush_ack", data_in_ack, 0);
    tick();
    chk("flush_level", fifo_level, 0);
    chk("flush_empty", fifo_empty, 1);
    chk("flush_space", fifo_space, 8);
    chk("flush_ovf", ovf_err, 0);

    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("udf_level", fifo_level, 0);
    chk("udf_set", udf_err, ERR_EN);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("udf_clr", udf_err, 0);

    drive(1'b1, 16'h00E1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("post_flush_level", fifo_level, 1);
    chk("post_flush_dout", data_out, 16'h00E1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
